// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-requester round-robin arbiter for the Hack data RAM.
// Requester 0 is the CPU data port, requester 1 the screen/DMA engine.
// Optional feature macro: ARB_BURST_EN (lock-based burst hold, up to MAX_HOLD
// consecutive grants). When undefined, contended requests strictly alternate.
module ram_port_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 16,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              last_q;
    logic [1:0]        rd_pend_q;   // read granted last edge, RAM data arrives this cycle
    logic [1:0]        rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic              win;
    logic              any_req;
    logic              gnt_en;
    logic              gnt_any;

    assign any_req = req0 | req1;
    // Grants are suppressed combinationally while reset is asserted.
    assign gnt_en  = ~reset & any_req;

`ifdef ARB_BURST_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] hold_q, hold_d;
    logic          win_lock;

    // Winner select: round-robin, overridden by an active burst hold.
    always_comb begin
        win = last_q;
        if (req0 & req1) begin
            if (hold_q == HW'(MAX_HOLD))
                win = ~last_q;
            else if (hold_q != '0)
                win = last_q;
            else
                win = ~last_q;
        end else if (req0) begin
            win = 1'b0;
        end else if (req1) begin
            win = 1'b1;
        end
    end

    assign win_lock = win ? lock1 : lock0;

    // Burst counter next state; only advances on a granted edge.
    always_comb begin
        hold_d = hold_q;
        if (gnt_any) begin
            if (win != last_q)
                hold_d = win_lock ? HW'(1) : '0;
            else if (hold_q == HW'(MAX_HOLD))
                hold_d = '0;
            else if (win_lock)
                hold_d = hold_q + HW'(1);
            else
                hold_d = '0;
        end
    end

    // Burst counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) hold_q <= '0;
        else       hold_q <= hold_d;
    end
`else
    logic unused_lock;
    assign unused_lock = lock0 ^ lock1;

    // Winner select: plain round-robin, contended requests alternate.
    always_comb begin
        win = last_q;
        if (req0 & req1)
            win = ~last_q;
        else if (req0)
            win = 1'b0;
        else if (req1)
            win = 1'b1;
    end
`endif

    assign gnt0    = gnt_en & req0 & ~win;
    assign gnt1    = gnt_en & req1 & win;
    assign gnt_any = gnt0 | gnt1;

    // Mux select follows the winner; parks on the last owner when idle.
    assign mem_sel   = reset ? 1'b1 : (any_req ? win : last_q);
    assign mem_addr  = mem_sel ? addr1 : addr0;
    assign mem_wdata = mem_sel ? wdata1 : wdata0;
    assign mem_we    = gnt_en & (win ? we1 : we0);

    // Round-robin owner register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        last_q <= 1'b1;
        else if (gnt_any) last_q <= win;
    end

    // Read return path: capture RAM data the cycle after a read grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend_q <= '0;
            rvalid_q  <= '0;
            rdata_q   <= '0;
        end else begin
            rd_pend_q <= {gnt1 & ~we1, gnt0 & ~we0};
            rvalid_q  <= rd_pend_q;
            if (|rd_pend_q) rdata_q <= mem_rdata;
        end
    end

    assign rvalid0 = rvalid_q[0];
    assign rvalid1 = rvalid_q[1];
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural synchronous RAM.
module tb_ram_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [14:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_sel, mem_we;
    logic [15:0] rdata, mem_wdata, mem_rdata;
    logic [14:0] mem_addr;
    logic [15:0] ram [0:32767];

    int n_tot = 0;
    int n_bad = 0;

    ram_port_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM: data valid one cycle after the address.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [9:0] exp4;

    initial begin
`ifdef ARB_BURST_EN
        exp4 = 10'b10_0001_0000;
`else
        exp4 = 10'b10_1010_1010;
`endif
        reset = 1'b1;
        {req0, req1, we0, we1, lock0, lock1} = '0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        tick; tick;
        chk("rst_rvalid0", rvalid0, 0);
        chk("rst_rvalid1", rvalid1, 0);
        chk("rst_rdata",   rdata, 0);
        chk("rst_sel",     mem_sel, 1);
        chk("rst_we",      mem_we, 0);
        reset = 1'b0;

        // 1: write from requester 0
        req0 = 1; we0 = 1; addr0 = 15'h0010; wdata0 = 16'h1234;
        #1;
        chk("t1_gnt0", gnt0, 1);
        chk("t1_gnt1", gnt1, 0);
        chk("t1_sel", mem_sel, 0);
        chk("t1_we", mem_we, 1);
        chk("t1_addr", mem_addr, 32'h10);
        chk("t1_wdata", mem_wdata, 32'h1234);
        tick; req0 = 0;
        tick;
        chk("t1_rv0", rvalid0, 0);
        chk("t1_rv1", rvalid1, 0);

        // read back the write through requester 0
        req0 = 1; we0 = 0; #1;
        chk("rb_gnt0", gnt0, 1);
        chk("rb_we", mem_we, 0);
        tick; req0 = 0;
        tick;
        chk("rb_rv0", rvalid0, 1);
        chk("rb_rdata", rdata, 32'h1234);

        // 2: requester 1 writes 0xBEEF then reads it
        req1 = 1; we1 = 1; addr1 = 15'h4000; wdata1 = 16'hBEEF; #1;
        chk("t2w_gnt1", gnt1, 1);
        tick; we1 = 0; #1;
        chk("t2_gnt1", gnt1, 1);
        chk("t2_sel", mem_sel, 1);
        chk("t2_we", mem_we, 0);
        tick; req1 = 0;
        chk("t2_rv1_early", rvalid1, 0);
        tick;
        chk("t2_rv1", rvalid1, 1);
        chk("t2_rv0", rvalid0, 0);
        chk("t2_rdata", rdata, 32'hBEEF);
        tick;
        chk("t2_rv1_pulse", rvalid1, 0);

        // 6: idle after grant to requester 1
        tick;
        chk("t6_sel", mem_sel, 1);
        chk("t6_we", mem_we, 0);
        chk("t6_gnt", {gnt0, gnt1}, 0);
        chk("t6_rdata", rdata, 32'hBEEF);

        // 3: contention without lock, alternating grants
        req0 = 1; req1 = 1; we0 = 1; we1 = 0; addr0 = 15'h0020; wdata0 = 16'h5555;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("t3_gnt0_%0d", i), gnt0, (i % 2) == 0);
            chk($sformatf("t3_gnt1_%0d", i), gnt1, (i % 2) == 1);
            chk($sformatf("t3_we_%0d", i), mem_we, (i % 2) == 0);
            tick;
        end

        // 4: requester 0 asks for lock under contention
        lock0 = 1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("t4_gnt1_%0d", i), gnt1, exp4[i]);
            chk($sformatf("t4_gnt0_%0d", i), gnt0, !exp4[i]);
            tick;
        end
        lock0 = 0; req0 = 0; req1 = 0;
        tick; tick;

        // 5: reset one cycle after a granted read
        req0 = 1; we0 = 0; addr0 = 15'h0010; #1;
        chk("t5_gnt0", gnt0, 1);
        tick; req0 = 0;
        reset = 1; #1;
        chk("t5_rv0_rst", rvalid0, 0);
        req0 = 1; req1 = 1; we0 = 1; we1 = 1; #1;
        chk("t5_gnt_rst", {gnt0, gnt1}, 0);
        chk("t5_we_rst", mem_we, 0);
        chk("t5_sel_rst", mem_sel, 1);
        tick;
        chk("t5_rv0_hold", rvalid0, 0);
        reset = 0; #1;
        chk("t5_gnt0_after", gnt0, 1);
        chk("t5_gnt1_after", gnt1, 0);
        tick; req0 = 0; req1 = 0;
        tick;
        chk("t5_rv0_after", rvalid0, 0);
        chk("t5_rv1_after", rvalid1, 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
